// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - opcode, field-position and class constants shared by the instruction field pipe
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int JTARG_W    = 26;

  typedef enum logic [1:0] {
    CLASS_NONE = 2'b00,
    CLASS_R    = 2'b01,
    CLASS_J    = 2'b10,
    CLASS_I    = 2'b11
  } instr_class_e;

endpackage

// File: rtl/instr_field_pipe_if.sv
// rtl/instr_field_pipe_if.sv - fetch/decode handshake bundle; out_class exists only with INSTR_CLASS_EN
interface instr_field_pipe_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm16;
  logic [31:0]     out_imm_ext;
  logic [PC_W-1:0] out_jaddr;
  logic [CW-1:0]   out_count;
`ifdef INSTR_CLASS_EN
  logic [1:0]      out_class;
`endif

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm16, out_imm_ext, out_jaddr, out_count
`ifdef INSTR_CLASS_EN
           , out_class
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm16, out_imm_ext, out_jaddr, out_count
`ifdef INSTR_CLASS_EN
           , out_class
`endif
  );

endinterface

// File: rtl/field_decode.sv
// rtl/field_decode.sv - combinational split of one instruction word plus PC into decode fields
// Optional out class output is built only with INSTR_CLASS_EN.
module field_decode
  import instr_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            en,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm16,
  output logic [31:0]     imm_ext,
  output logic [PC_W-1:0] jaddr
`ifdef INSTR_CLASS_EN
  ,
  output logic [1:0]      cls
`endif
);

  // Low 28 bits of the jump target come from the word; the rest from pc+4.
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(28'hFFF_FFFF);

  logic [5:0]      op_raw;
  logic [15:0]     imm_raw;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] jaddr_full;
  logic [31:0]     imm_full;

  assign op_raw     = instr[OPCODE_LSB +: 6];
  assign imm_raw    = instr[15:0];
  assign pc_plus4   = pc + PC_W'(4);
  assign jaddr_full = (pc_plus4 & ~LOW_MASK) | PC_W'({instr[JTARG_W-1:0], 2'b00});

  always_comb begin
    imm_full = {{16{imm_raw[15]}}, imm_raw};
    case (op_raw)
      OP_ANDI, OP_ORI, OP_XORI: imm_full = {16'h0000, imm_raw};
      OP_LUI:                   imm_full = {imm_raw, 16'h0000};
      default:                  imm_full = {{16{imm_raw[15]}}, imm_raw};
    endcase
  end

  always_comb begin
    opcode  = '0;
    rs      = '0;
    rt      = '0;
    rd      = '0;
    shamt   = '0;
    funct   = '0;
    imm16   = '0;
    imm_ext = '0;
    jaddr   = '0;
    if (en) begin
      opcode  = op_raw;
      rs      = instr[RS_LSB +: 5];
      rt      = instr[RT_LSB +: 5];
      rd      = instr[RD_LSB +: 5];
      shamt   = instr[SHAMT_LSB +: 5];
      funct   = instr[FUNCT_LSB +: 6];
      imm16   = imm_raw;
      imm_ext = imm_full;
      jaddr   = jaddr_full;
    end
  end

`ifdef INSTR_CLASS_EN
  always_comb begin
    cls = CLASS_NONE;
    if (en) begin
      if (op_raw == OP_RTYPE)                      cls = CLASS_R;
      else if (op_raw == OP_J || op_raw == OP_JAL) cls = CLASS_J;
      else                                         cls = CLASS_I;
    end
  end
`endif

endmodule

// File: rtl/instr_field_pipe.sv
// rtl/instr_field_pipe.sv - fetch-to-decode FIFO presenting decoded fields of its head entry
// Optional INSTR_CLASS_EN adds the out_class output through the interface.
module instr_field_pipe
  import instr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  instr_field_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // in_ready looks only at occupancy, so a full FIFO refuses even when popping.
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = !empty && bus.out_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_count = count;
  assign bus.out_pc    = empty ? '0 : pc_mem[rd_ptr];

  field_decode #(.PC_W(PC_W)) u_decode (
    .en      (!empty),
    .instr   (instr_mem[rd_ptr]),
    .pc      (pc_mem[rd_ptr]),
    .opcode  (bus.out_opcode),
    .rs      (bus.out_rs),
    .rt      (bus.out_rt),
    .rd      (bus.out_rd),
    .shamt   (bus.out_shamt),
    .funct   (bus.out_funct),
    .imm16   (bus.out_imm16),
    .imm_ext (bus.out_imm_ext),
    .jaddr   (bus.out_jaddr)
`ifdef INSTR_CLASS_EN
    ,
    .cls     (bus.out_class)
`endif
  );

endmodule

// File: tb/tb_instr_field_pipe.sv
// tb/tb_instr_field_pipe.sv - directed self-checking bench for instr_field_pipe (DEPTH=2, PC_W=32)
module tb_instr_field_pipe;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  instr_field_pipe_if #(.DEPTH(2), .PC_W(32)) bus ();

  instr_field_pipe #(.DEPTH(2), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imm_instr [6];
  logic [31:0] imm_exp   [6];
  logic [4:0]  imm_rt    [6];
  initial begin
    imm_instr = '{32'h34088000, 32'h8C28FFFC, 32'h3C011234, 32'h3008FFFF, 32'h2008FFFF, 32'h3808FFFF};
    imm_exp   = '{32'h00008000, 32'hFFFFFFFC, 32'h12340000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0000FFFF};
    imm_rt    = '{5'd8, 5'd8, 5'd1, 5'd8, 5'd8, 5'd8};
  end

  task automatic push_word(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_word();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", bus.out_count); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.out_pc); else passed++;
    total++; if (bus.out_jaddr !== 32'h0) $display("FAIL reset_jaddr got %h exp 0", bus.out_jaddr); else passed++;
    total++; if (bus.out_imm_ext !== 32'h0) $display("FAIL reset_imm_ext got %h exp 0", bus.out_imm_ext); else passed++;
`ifdef INSTR_CLASS_EN
    total++; if (bus.out_class !== 2'b00) $display("FAIL reset_class got %b exp 00", bus.out_class); else passed++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    push_word(32'h00221821, 32'h00003000);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL rtype_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_opcode !== 6'd0) $display("FAIL rtype_opcode got %h exp 0", bus.out_opcode); else passed++;
    total++; if (bus.out_rs !== 5'd1) $display("FAIL rtype_rs got %0d exp 1", bus.out_rs); else passed++;
    total++; if (bus.out_rt !== 5'd2) $display("FAIL rtype_rt got %0d exp 2", bus.out_rt); else passed++;
    total++; if (bus.out_rd !== 5'd3) $display("FAIL rtype_rd got %0d exp 3", bus.out_rd); else passed++;
    total++; if (bus.out_shamt !== 5'd0) $display("FAIL rtype_shamt got %0d exp 0", bus.out_shamt); else passed++;
    total++; if (bus.out_funct !== 6'h21) $display("FAIL rtype_funct got %h exp 21", bus.out_funct); else passed++;
    total++; if (bus.out_count !== 2'd1) $display("FAIL rtype_count got %0d exp 1", bus.out_count); else passed++;
    total++; if (bus.out_pc !== 32'h00003000) $display("FAIL rtype_pc got %h exp 00003000", bus.out_pc); else passed++;
    total++; if (bus.out_imm16 !== 16'h1821) $display("FAIL rtype_imm16 got %h exp 1821", bus.out_imm16); else passed++;
`ifdef INSTR_CLASS_EN
    total++; if (bus.out_class !== 2'b01) $display("FAIL rtype_class got %b exp 01", bus.out_class); else passed++;
`endif
    pop_word();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rtype_drained got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_imm_ext();
    for (int i = 0; i < 6; i++) begin
      push_word(imm_instr[i], 32'h00003004);
      total++; if (bus.out_imm_ext !== imm_exp[i]) $display("FAIL imm_ext[%0d] got %h exp %h", i, bus.out_imm_ext, imm_exp[i]); else passed++;
      total++; if (bus.out_rt !== imm_rt[i]) $display("FAIL imm_rt[%0d] got %0d exp %0d", i, bus.out_rt, imm_rt[i]); else passed++;
`ifdef INSTR_CLASS_EN
      total++; if (bus.out_class !== 2'b11) $display("FAIL imm_class[%0d] got %b exp 11", i, bus.out_class); else passed++;
`endif
      pop_word();
    end
    push_word(32'h8C28FFFC, 32'h00003004);
    total++; if (bus.out_rs !== 5'd1) $display("FAIL lw_rs got %0d exp 1", bus.out_rs); else passed++;
    total++; if (bus.out_opcode !== 6'h23) $display("FAIL lw_opcode got %h exp 23", bus.out_opcode); else passed++;
    pop_word();
  endtask

  task automatic test_jump();
    push_word(32'h08000004, 32'h00003008);
    total++; if (bus.out_jaddr !== 32'h00000010) $display("FAIL j_jaddr got %h exp 00000010", bus.out_jaddr); else passed++;
`ifdef INSTR_CLASS_EN
    total++; if (bus.out_class !== 2'b10) $display("FAIL j_class got %b exp 10", bus.out_class); else passed++;
`endif
    pop_word();
    push_word(32'h0C000001, 32'h7FFFFFFC);
    total++; if (bus.out_jaddr !== 32'h80000004) $display("FAIL jal_carry_jaddr got %h exp 80000004", bus.out_jaddr); else passed++;
`ifdef INSTR_CLASS_EN
    total++; if (bus.out_class !== 2'b10) $display("FAIL jal_class got %b exp 10", bus.out_class); else passed++;
`endif
    pop_word();
    push_word(32'h0C000001, 32'hFFFFFFFC);
    total++; if (bus.out_jaddr !== 32'h00000004) $display("FAIL jal_wrap_jaddr got %h exp 00000004", bus.out_jaddr); else passed++;
    pop_word();
  endtask

  task automatic test_full();
    push_word(32'h20000001, 32'h00000100);
    push_word(32'h20000002, 32'h00000104);
    total++; if (bus.out_count !== 2'd2) $display("FAIL full_count got %0d exp 2", bus.out_count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", bus.in_ready); else passed++;
    push_word(32'h20000003, 32'h00000108);
    total++; if (bus.out_count !== 2'd2) $display("FAIL full_reject_count got %0d exp 2", bus.out_count); else passed++;
    total++; if (bus.out_pc !== 32'h00000100) $display("FAIL full_head got %h exp 00000100", bus.out_pc); else passed++;
    // offer the third word again while popping: full at the edge, so it must be refused
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    total++; if (bus.out_count !== 2'd1) $display("FAIL pop_full_count got %0d exp 1", bus.out_count); else passed++;
    total++; if (bus.out_pc !== 32'h00000104) $display("FAIL pop_full_head got %h exp 00000104", bus.out_pc); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL pop_full_in_ready got %b exp 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.out_count !== 2'd0) $display("FAIL drain_count got %0d exp 0", bus.out_count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_instr = 32'h20000000 | i;
      bus.in_pc    = 32'h00004000 + 32'(4 * i);
      @(posedge clk); #1;
      total++; if (bus.out_pc !== 32'h00004000 + 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.out_pc, 32'h00004000 + 32'(4 * i)); else passed++;
      total++; if (bus.out_imm16 !== 16'(i)) $display("FAIL stream_imm16[%0d] got %h exp %h", i, bus.out_imm16, 16'(i)); else passed++;
      total++; if (bus.out_count !== 2'd1) $display("FAIL stream_count[%0d] got %0d exp 1", i, bus.out_count); else passed++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.out_count !== 2'd0) $display("FAIL stream_end_count got %0d exp 0", bus.out_count); else passed++;
  endtask

  task automatic test_flush();
    push_word(32'h20000011, 32'h00000200);
    push_word(32'h20000012, 32'h00000204);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h20000013;
    bus.in_pc    = 32'h00000208;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_count !== 2'd0) $display("FAIL flush_count got %0d exp 0", bus.out_count); else passed++;
    total++; if (bus.out_imm16 !== 16'h0) $display("FAIL flush_imm16 got %h exp 0", bus.out_imm16); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL flush_pc got %h exp 0", bus.out_pc); else passed++;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_dropped got %b exp 0", bus.out_valid); else passed++;
    push_word(32'h20000014, 32'h0000020C);
    total++; if (bus.out_pc !== 32'h0000020C) $display("FAIL post_flush_head got %h exp 0000020C", bus.out_pc); else passed++;
    pop_word();
  endtask

  task automatic test_async_reset();
    push_word(32'h20000021, 32'h00000300);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL areset_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_count !== 2'd0) $display("FAIL areset_count got %0d exp 0", bus.out_count); else passed++;
    total++; if (bus.out_pc !== 32'h0) $display("FAIL areset_pc got %h exp 0", bus.out_pc); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_word(32'h20000022, 32'h00000304);
    total++; if (bus.out_pc !== 32'h00000304) $display("FAIL areset_next_head got %h exp 00000304", bus.out_pc); else passed++;
    pop_word();
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rtype();
    test_imm_ext();
    test_jump();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_field_pipe.md
Name: instr_field_pipe

Overview:
Registered successor to the combinational instruction field splitter. Buffers fetched instructions and their PCs in a parametrised FIFO with a valid/ready handshake, and presents decoded fields of the head entry to the decode stage. Fields are opcode, rs, rt, rd, shamt, funct, imm16, extended immediate and jump target. Sits between fetch and decode; absorbs decode stalls and supports branch flush.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
PC_W, 32, PC width; >= 28 for jump-target formation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers an entry
in_ready  out  1  FIFO can accept (= !full)
in_instr  in  32  instruction word
in_pc  in  PC_W  PC of in_instr
flush  in  1  synchronous discard of all entries
out_valid  out  1  head entry valid (= !empty)
out_ready  in  1  decode consumes head
out_pc  out  PC_W  head PC
out_opcode  out  6  instr[31:26]
out_rs  out  5  instr[25:21]
out_rt  out  5  instr[20:16]
out_rd  out  5  instr[15:11]
out_shamt  out  5  instr[10:6]
out_funct  out  6  instr[5:0]
out_imm16  out  16  instr[15:0]
out_imm_ext  out  32  extended immediate
out_jaddr  out  PC_W  {pc_plus4[PC_W-1:28], instr[25:0], 2'b00}
out_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_n low, async): rd/wr pointers 0, count 0. in_ready=1, out_valid=0, out_count=0. All field/pc outputs 0. Storage need not be reset.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N; one-cycle minimum, no bypass.
- in_ready depends on occupancy only, never on out_ready. When full, no push is accepted even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is 0..DEPTH.
- flush: has priority over push and pop. Next cycle count=0, pointers=0, out_valid=0; the same-cycle in_valid entry is dropped.
- Field outputs are combinational from the head entry, gated to 0 when out_valid=0.
- out_imm_ext: zero-extended for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori). For 0x0F (lui) it is {imm16,16'h0}. Otherwise sign-extended.
- out_jaddr: pc_plus4 = out_pc + 4, truncated to PC_W. Upper bits [PC_W-1:28] are taken from pc_plus4.
- Reset asserted mid-transfer: all state cleared immediately; an in-flight handshake is lost.

Optional Feature:
INSTR_CLASS_EN: when defined, adds output out_class[1:0], 0 when empty:
- 2'b01 = R-type (opcode 0)
- 2'b10 = J-type (opcode 2 or 3)
- 2'b11 = I-type (all other opcodes)

When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
Shared package instr_pkg holds:
- opcode constants OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, OP_LUI
- field bit-position constants
- class encoding constants

Sub-module field_decode is natural: purely combinational 32-bit word + PC to fields, imm_ext and jaddr. The top holds the FIFO, pointers and handshake.

Test Plan:
- Reset, then push 0x00221821 at pc 0x00003000 -> next cycle: out_valid=1, opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 0x21, out_count=1.
- Push 0x34088000 (ori) -> imm_ext 0x00008000. Push 0x8C28FFFC (lw) -> rs 1, rt 8, imm_ext 0xFFFFFFFC. Push 0x3C011234 (lui) -> imm_ext 0x12340000.
- Push 0x08000004 at pc 0x00003008 -> out_jaddr 0x00000010. With INSTR_CLASS_EN defined -> out_class 2'b10.
- Hold out_ready=0 and push DEPTH=2 entries -> in_ready=0, count 2. A third in_valid is not accepted. Raise out_ready -> entries drain in order; in_ready=1 the cycle after the first pop.
- Steady stream with in_valid=out_ready=1 -> one entry per cycle, count stays 1, pointers wrap with no loss or duplication across 10 words.
- flush asserted with count=2 and in_valid=1 -> next cycle: out_valid=0, count 0, fields 0, and the flushed-cycle word never appears.
